// File: rtl/dpram_port_arbiter.sv
// Two-client round-robin arbiter for a dual-port RAM with a hardware clear sweep.
// Write and read ports are arbitrated independently; read data returns one cycle later.
module dpram_port_arbiter #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  c0_req_i,
    input  logic                  c0_we_i,
    input  logic [ADDR_WIDTH-1:0] c0_addr_i,
    input  logic [WIDTH-1:0]      c0_wdata_i,
    output logic                  c0_gnt_o,
    output logic                  c0_rvalid_o,
    output logic [WIDTH-1:0]      c0_rdata_o,
    input  logic                  c1_req_i,
    input  logic                  c1_we_i,
    input  logic [ADDR_WIDTH-1:0] c1_addr_i,
    input  logic [WIDTH-1:0]      c1_wdata_i,
    output logic                  c1_gnt_o,
    output logic                  c1_rvalid_o,
    output logic [WIDTH-1:0]      c1_rdata_o,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [WIDTH-1:0]      ram_wdata_o,
    output logic                  ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [WIDTH-1:0]      ram_rdata_i
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic                  state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic                  ret_vld_q, ret_vld_d;
    logic                  ret_id_q, ret_id_d;

    logic w0, w1, r0, r1;
    logic wg0, wg1, rg0, rg1;

    assign w0 = c0_req_i & c0_we_i;
    assign w1 = c1_req_i & c1_we_i;
    assign r0 = c0_req_i & ~c0_we_i;
    assign r1 = c1_req_i & ~c1_we_i;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        ret_vld_d     = 1'b0;
        ret_id_d      = ret_id_q;
        wg0           = 1'b0;
        wg1           = 1'b0;
        rg0           = 1'b0;
        rg1           = 1'b0;
        busy_o        = 1'b0;
        ram_wr_en_o   = 1'b0;
        ram_wr_addr_o = '0;
        ram_wdata_o   = '0;
        ram_rd_en_o   = 1'b0;
        ram_rd_addr_o = '0;

        // Reset cycle leaves every output at its forced-zero default
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                busy_o        = 1'b1;
                ram_wr_en_o   = 1'b1;
                ram_wr_addr_o = cnt_q;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end else begin
                wg0 = w0 & (~w1 | ~wptr_q);
                wg1 = w1 & (~w0 | wptr_q);
                rg0 = r0 & (~r1 | ~rptr_q);
                rg1 = r1 & (~r0 | rptr_q);
                if (w0 && w1) wptr_d = ~wptr_q;
                if (r0 && r1) rptr_d = ~rptr_q;

                ram_wr_en_o = wg0 | wg1;
                if (wg0) begin
                    ram_wr_addr_o = c0_addr_i;
                    ram_wdata_o   = c0_wdata_i;
                end else if (wg1) begin
                    ram_wr_addr_o = c1_addr_i;
                    ram_wdata_o   = c1_wdata_i;
                end

                ram_rd_en_o = rg0 | rg1;
                if (rg0) begin
                    ram_rd_addr_o = c0_addr_i;
                end else if (rg1) begin
                    ram_rd_addr_o = c1_addr_i;
                end

                ret_vld_d = rg0 | rg1;
                ret_id_d  = rg1;

                if (clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        end
    end

    assign c0_gnt_o    = wg0 | rg0;
    assign c1_gnt_o    = wg1 | rg1;
    assign c0_rvalid_o = ret_vld_q & ~ret_id_q & ~rst_i;
    assign c1_rvalid_o = ret_vld_q & ret_id_q & ~rst_i;
    assign c0_rdata_o  = ram_rdata_i;
    assign c1_rdata_o  = ram_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            ret_vld_q <= 1'b0;
            ret_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ret_vld_q <= ret_vld_d;
            ret_id_q  <= ret_id_d;
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter with a write-first registered RAM beside it.
// Directed scenarios plus a randomized run against a behavioural model.
module tb_dpram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c0_req = 1'b0, c0_we = 1'b0;
    logic [7:0]  c0_addr = '0;
    logic [15:0] c0_wdata = '0;
    logic        c0_gnt, c0_rvalid;
    logic [15:0] c0_rdata;
    logic        c1_req = 1'b0, c1_we = 1'b0;
    logic [7:0]  c1_addr = '0;
    logic [15:0] c1_wdata = '0;
    logic        c1_gnt, c1_rvalid;
    logic [15:0] c1_rdata;
    logic        clr = 1'b0;
    logic        busy;
    logic        ram_wr_en, ram_rd_en;
    logic [7:0]  ram_wr_addr, ram_rd_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic [15:0] ram [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(.WIDTH(16), .DEPTH(256), .ADDR_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .c0_req_i(c0_req), .c0_we_i(c0_we), .c0_addr_i(c0_addr),
        .c0_wdata_i(c0_wdata), .c0_gnt_o(c0_gnt),
        .c0_rvalid_o(c0_rvalid), .c0_rdata_o(c0_rdata),
        .c1_req_i(c1_req), .c1_we_i(c1_we), .c1_addr_i(c1_addr),
        .c1_wdata_i(c1_wdata), .c1_gnt_o(c1_gnt),
        .c1_rvalid_o(c1_rvalid), .c1_rdata_o(c1_rdata),
        .clr_i(clr), .busy_o(busy),
        .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr),
        .ram_wdata_o(ram_wdata), .ram_rd_en_o(ram_rd_en),
        .ram_rd_addr_o(ram_rd_addr), .ram_rdata_i(ram_rdata)
    );

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
    end

    // Dual-port RAM: registered read, write-first on address collision
    always @(posedge clk) begin
        if (ram_wr_en) ram[ram_wr_addr] <= ram_wdata;
        if (ram_rd_en)
            ram_rdata <= (ram_wr_en && ram_wr_addr == ram_rd_addr) ? ram_wdata : ram[ram_rd_addr];
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        c0_req = 1'b0;
        c1_req = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle();
        nxt();
        rst = 1'b0;
    endtask

    task automatic c0_set(input logic we, input logic [7:0] a, input logic [15:0] d);
        c0_req = 1'b1; c0_we = we; c0_addr = a; c0_wdata = d;
    endtask

    task automatic c1_set(input logic we, input logic [7:0] a, input logic [15:0] d);
        c1_req = 1'b1; c1_we = we; c1_addr = a; c1_wdata = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        c0_set(1'b1, 8'h01, 16'h1234);
        c1_set(1'b0, 8'h02, 16'h0);
        @(negedge clk);
        checks++;
        if ({c0_gnt, c1_gnt, ram_wr_en, ram_rd_en} !== 4'b0) begin
            errors++;
            $display("FAIL reset_forced: gnt/en=%b expected 0000", {c0_gnt, c1_gnt, ram_wr_en, ram_rd_en});
        end
        checks++;
        if ({busy, c0_rvalid, c1_rvalid} !== 3'b0) begin
            errors++;
            $display("FAIL reset_busy_rv: %b expected 000", {busy, c0_rvalid, c1_rvalid});
        end
        nxt();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if ({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, busy, ram_wr_en, ram_rd_en, ram_wr_addr, ram_rd_addr, ram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_idle: outputs %h expected 0",
                {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, busy, ram_wr_en, ram_rd_en, ram_wr_addr, ram_rd_addr, ram_wdata});
        end
        nxt();
    endtask

    task automatic test_write_read;
        c0_set(1'b1, 8'h10, 16'hABCD);
        @(negedge clk);
        checks++;
        if ({c0_gnt, c1_gnt, ram_wr_en, ram_wr_addr, ram_wdata} !== {3'b101, 8'h10, 16'hABCD}) begin
            errors++;
            $display("FAIL wr_grant: got %h expected %h",
                {c0_gnt, c1_gnt, ram_wr_en, ram_wr_addr, ram_wdata}, {3'b101, 8'h10, 16'hABCD});
        end
        nxt();
        idle();
        c1_set(1'b0, 8'h10, 16'h0);
        @(negedge clk);
        checks++;
        if ({c1_gnt, ram_rd_en, ram_rd_addr, ram_wr_en} !== {2'b11, 8'h10, 1'b0}) begin
            errors++;
            $display("FAIL rd_grant: got %h expected %h", {c1_gnt, ram_rd_en, ram_rd_addr, ram_wr_en}, {2'b11, 8'h10, 1'b0});
        end
        nxt();
        idle();
        @(negedge clk);
        checks++;
        if ({c1_rvalid, c0_rvalid, c1_rdata} !== {2'b10, 16'hABCD}) begin
            errors++;
            $display("FAIL rd_return: got %h expected %h", {c1_rvalid, c0_rvalid, c1_rdata}, {2'b10, 16'hABCD});
        end
        nxt();
    endtask

    task automatic test_contended_writes;
        logic [1:0] eg;
        do_reset();
        c0_set(1'b1, 8'h20, 16'h2020);
        c1_set(1'b1, 8'h21, 16'h2121);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({c1_gnt, c0_gnt} !== eg || ram_wr_addr !== (eg[1] ? 8'h21 : 8'h20)) begin
                errors++;
                $display("FAIL contended_wr[%0d]: gnt=%b addr=%h expected gnt=%b", i, {c1_gnt, c0_gnt}, ram_wr_addr, eg);
            end
            nxt();
        end
        idle();
    endtask

    task automatic test_same_cycle;
        c0_set(1'b1, 8'h05, 16'h1111);
        c1_set(1'b0, 8'h05, 16'h0);
        @(negedge clk);
        checks++;
        if ({c0_gnt, c1_gnt, ram_wr_en, ram_rd_en} !== 4'b1111) begin
            errors++;
            $display("FAIL same_cycle_gnt: got %b expected 1111", {c0_gnt, c1_gnt, ram_wr_en, ram_rd_en});
        end
        nxt();
        idle();
        @(negedge clk);
        checks++;
        if ({c1_rvalid, c1_rdata} !== {1'b1, 16'h1111}) begin
            errors++;
            $display("FAIL same_cycle_data: got %h expected %h", {c1_rvalid, c1_rdata}, {1'b1, 16'h1111});
        end
        nxt();
    endtask

    task automatic test_clear;
        int  cnt;
        bit  done;
        for (int a = 0; a < 4; a++) begin
            c0_set(1'b1, 8'(a), 16'hA000 + 16'(a));
            nxt();
        end
        idle();
        clr = 1'b1;
        nxt();
        clr = 1'b0;
        c0_set(1'b0, 8'h03, 16'h0);
        c1_set(1'b1, 8'h02, 16'hFFFF);
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (busy) begin
                checks++;
                if ({c0_gnt, c1_gnt, ram_rd_en, ram_wr_en} !== 4'b0001 || ram_wr_addr !== 8'(cnt) || ram_wdata !== 16'h0) begin
                    errors++;
                    $display("FAIL sweep[%0d]: gnt/en=%b addr=%h data=%h expected 0001 %h 0000",
                        cnt, {c0_gnt, c1_gnt, ram_rd_en, ram_wr_en}, ram_wr_addr, ram_wdata, 8'(cnt));
                end
                cnt++;
                nxt();
            end else begin
                done = 1'b1;
                idle();
            end
        end
        checks++;
        if (cnt != 256) begin
            errors++;
            $display("FAIL sweep_len: busy cycles %0d expected 256", cnt);
        end
        nxt();
        c0_set(1'b0, 8'h03, 16'h0);
        nxt();
        idle();
        @(negedge clk);
        checks++;
        if ({c0_rvalid, c0_rdata} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL clear_read: got %h expected %h", {c0_rvalid, c0_rdata}, {1'b1, 16'h0000});
        end
        nxt();
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        bit done;
        c0_set(1'b1, 8'hC8, 16'hBEEF);
        nxt();
        idle();
        clr = 1'b1;
        nxt();
        clr = 1'b0;
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (busy && cnt == 100) begin
                rst = 1'b1;
                done = 1'b1;
                #1;
                checks++;
                if ({busy, ram_wr_en} !== 2'b00) begin
                    errors++;
                    $display("FAIL mid_rst_forced: busy/wr_en=%b expected 00", {busy, ram_wr_en});
                end
            end else if (busy) begin
                cnt++;
                nxt();
            end else begin
                done = 1'b1;
            end
        end
        checks++;
        if (cnt != 100) begin
            errors++;
            $display("FAIL mid_rst_reach: sweep cycles %0d expected 100", cnt);
        end
        nxt();
        rst = 1'b0;
        c0_set(1'b1, 8'h30, 16'h3030);
        c1_set(1'b1, 8'h31, 16'h3131);
        @(negedge clk);
        checks++;
        if ({busy, c1_gnt, c0_gnt, ram_wr_addr} !== {3'b001, 8'h30}) begin
            errors++;
            $display("FAIL mid_rst_after: busy/gnt=%b addr=%h expected 001 30", {busy, c1_gnt, c0_gnt}, ram_wr_addr);
        end
        nxt();
        idle();
        c0_set(1'b0, 8'hC8, 16'h0);
        nxt();
        c0_set(1'b0, 8'd50, 16'h0);
        @(negedge clk);
        checks++;
        if ({c0_rvalid, c0_rdata} !== {1'b1, 16'hBEEF}) begin
            errors++;
            $display("FAIL mid_rst_keep: got %h expected %h", {c0_rvalid, c0_rdata}, {1'b1, 16'hBEEF});
        end
        nxt();
        idle();
        @(negedge clk);
        checks++;
        if ({c0_rvalid, c0_rdata} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL mid_rst_swept: got %h expected %h", {c0_rvalid, c0_rdata}, {1'b1, 16'h0000});
        end
        nxt();
    endtask

    task automatic test_back_to_back;
        logic [1:0] eg;
        logic [1:0] ev;
        do_reset();
        c0_set(1'b0, 8'h40, 16'h0);
        c1_set(1'b0, 8'h41, 16'h0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) begin
                eg = (i % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if ({c1_gnt, c0_gnt} !== eg) begin
                    errors++;
                    $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, {c1_gnt, c0_gnt}, eg);
                end
            end
            if (i > 0) begin
                ev = ((i - 1) % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if ({c1_rvalid, c0_rvalid} !== ev) begin
                    errors++;
                    $display("FAIL b2b_rvalid[%0d]: got %b expected %b", i, {c1_rvalid, c0_rvalid}, ev);
                end
            end
            nxt();
            if (i == 5) idle();
        end
    endtask

    task automatic test_random;
        logic [15:0] mem [8];
        int          wc, rc;
        bit          w0, w1, r0, r1, ww, rw, eg0, eg1, free0, free1, done;
        logic [1:0]  prv;
        logic [15:0] prd, got;
        logic [7:0]  ewa, era;
        logic [15:0] ewd;
        idle();
        clr = 1'b1;
        nxt();
        clr = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            else nxt();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rand_clear_timeout: busy still %b after 300 cycles", busy);
        end
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = '0;
        wc = 0; rc = 0; prv = 2'b00; prd = '0;
        free0 = 1'b1; free1 = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (free0) c0_set(1'b1, 8'($urandom % 8), 16'($urandom));
            if (free0) begin c0_req = ($urandom % 4) != 0; c0_we = $urandom % 2; end
            if (free1) c1_set(1'b1, 8'($urandom % 8), 16'($urandom));
            if (free1) begin c1_req = ($urandom % 4) != 0; c1_we = $urandom % 2; end
            @(negedge clk);
            w0 = c0_req && c0_we;  w1 = c1_req && c1_we;
            r0 = c0_req && !c0_we; r1 = c1_req && !c1_we;
            // Contended winners alternate, client 0 taking the even-numbered contests
            ww = (w0 && w1) ? (wc % 2 == 1) : w1;
            rw = (r0 && r1) ? (rc % 2 == 1) : r1;
            eg0 = (w0 && !ww) || (r0 && !rw);
            eg1 = (w1 && ww) || (r1 && rw);
            ewa = (w0 || w1) ? (ww ? c1_addr : c0_addr) : 8'h0;
            ewd = (w0 || w1) ? (ww ? c1_wdata : c0_wdata) : 16'h0;
            era = (r0 || r1) ? (rw ? c1_addr : c0_addr) : 8'h0;
            checks++;
            if ({c1_gnt, c0_gnt} !== {eg1, eg0}) begin
                errors++;
                $display("FAIL rand_gnt[%0d]: got %b expected %b", n, {c1_gnt, c0_gnt}, {eg1, eg0});
            end
            checks++;
            if ({ram_wr_en, ram_wr_addr, ram_wdata} !== {w0 || w1, ewa, ewd}) begin
                errors++;
                $display("FAIL rand_wr[%0d]: got %h expected %h", n, {ram_wr_en, ram_wr_addr, ram_wdata}, {w0 || w1, ewa, ewd});
            end
            checks++;
            if ({ram_rd_en, ram_rd_addr} !== {r0 || r1, era}) begin
                errors++;
                $display("FAIL rand_rd[%0d]: got %h expected %h", n, {ram_rd_en, ram_rd_addr}, {r0 || r1, era});
            end
            checks++;
            if ({c1_rvalid, c0_rvalid} !== prv) begin
                errors++;
                $display("FAIL rand_rvalid[%0d]: got %b expected %b", n, {c1_rvalid, c0_rvalid}, prv);
            end
            if (prv != 2'b00) begin
                got = prv[1] ? c1_rdata : c0_rdata;
                checks++;
                if (got !== prd) begin
                    errors++;
                    $display("FAIL rand_rdata[%0d]: got %h expected %h", n, got, prd);
                end
            end
            if (w0 || w1) mem[ewa[2:0]] = ewd;
            if (r0 || r1) begin
                prd = mem[era[2:0]];
                prv = rw ? 2'b10 : 2'b01;
            end else begin
                prv = 2'b00;
            end
            if (w0 && w1) wc++;
            if (r0 && r1) rc++;
            free0 = !c0_req || eg0;
            free1 = !c1_req || eg1;
            nxt();
        end
        idle();
        nxt();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contended_writes();
        test_same_cycle();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Two-client round-robin arbiter and sequencer in front of the team's dual-port RAM: one write port, one read port, both on the same clock.
- Arbitrates the RAM write port and the RAM read port independently between client 0 and client 1.
- Routes registered read data back to the requesting client.
- Provides a hardware clear sequencer that sweeps zeros through every RAM address using the write port.

Parameters:
WIDTH, 16, data width; must equal the RAM's WIDTH
DEPTH, 256, number of RAM words; must equal the RAM's DEPTH
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
c0_req_i  in  1  client 0 request valid
c0_we_i  in  1  client 0 request type: 1 = write, 0 = read
c0_addr_i  in  ADDR_WIDTH  client 0 address
c0_wdata_i  in  WIDTH  client 0 write data
c0_gnt_o  out  1  client 0 request accepted this cycle
c0_rvalid_o  out  1  client 0 read data valid
c0_rdata_o  out  WIDTH  client 0 read data
c1_* (req_i, we_i, addr_i, wdata_i, gnt_o, rvalid_o, rdata_o)  same as c0_*, for client 1
clr_i  in  1  start clear sweep (single-cycle pulse)
busy_o  out  1  clear sweep in progress
ram_wr_en_o  out  1  RAM write enable
ram_wr_addr_o  out  ADDR_WIDTH  RAM write address
ram_wdata_o  out  WIDTH  RAM write data
ram_rd_en_o  out  1  RAM read enable
ram_rd_addr_o  out  ADDR_WIDTH  RAM read address
ram_rdata_i  in  WIDTH  RAM registered read data

Behaviour:
- Handshake:
  - A client holds req/we/addr/wdata stable until gnt is seen high.
  - gnt is combinational from current requests and state; a request is accepted in the cycle gnt=1.
- Write and read arbitration are independent. In one cycle, one write (from either client) and one read (from either client) can both be granted.
- Write arbiter:
  - Candidates are clients with req=1 and we=1.
  - If only one is a candidate, it is granted.
  - If both are candidates, the client indicated by the write round-robin pointer wins; the pointer then moves to the other client.
  - The pointer changes only on a contended grant.
- Read arbiter: same rules as the write arbiter, using its own read pointer and candidates with req=1 and we=0.
- RAM drive:
  - ram_wr_en_o, ram_wr_addr_o and ram_wdata_o are combinational copies of the winning write request.
  - ram_rd_en_o and ram_rd_addr_o are combinational copies of the winning read request.
  - Address and data outputs are 0 when the corresponding enable is 0.
- Read return:
  - A 2-bit return register {valid, client id} is loaded on each read grant.
  - One cycle after the grant, cN_rvalid_o=1 for exactly one cycle for the granting client.
  - cN_rdata_o = ram_rdata_i for both clients (passthrough), qualified only by rvalid.
  - Back-to-back reads sustain one result per cycle.
- Same-address read and write in one cycle: the RAM returns the newly written data (write-first). The arbiter adds no hazard logic.
- Clear FSM states:
  - IDLE: normal arbitration. clr_i=1 -> CLEAR, clear counter = 0. Requests presented in the same cycle as clr_i are still arbitrated normally.
  - CLEAR:
    - busy_o=1; both gnt outputs 0; reads blocked.
    - Each cycle: ram_wr_en_o=1, ram_wr_addr_o=counter, ram_wdata_o=0; counter increments.
    - At counter = DEPTH-1: that write is issued, then -> IDLE.
    - The sweep takes exactly DEPTH cycles.
  - clr_i while in CLEAR is ignored (no restart).
  - Read returns already in flight when CLEAR is entered still complete on the next cycle.
- Reset (rst_i=1 at a clock edge):
  - FSM -> IDLE; both pointers -> client 0; return register cleared; counter = 0.
  - A sweep in progress is abandoned mid-way.
  - During the reset cycle: all gnt, rvalid and ram enables are forced to 0, and busy_o=0.
  - All outputs return to their defined idle values the cycle after reset.
- Counter width is ADDR_WIDTH. The terminal-count compare prevents wrap-around.

Test Plan:
- Reset, then c0 writes addr 0x10 = 0xABCD, then c1 reads 0x10 -> c1_rvalid_o=1 on the cycle after the read grant, c1_rdata_o=0xABCD, c0_rvalid_o=0.
- Both clients hold write requests continuously for 4 cycles starting from reset -> grants alternate c0,c1,c0,c1; ram_wr_addr_o follows the winning client.
- In the same cycle, c0 writes 0x05 = 0x1111 and c1 reads 0x05 -> both granted; next cycle c1_rdata_o=0x1111.
- Fill addresses 0..3 with nonzero data, pulse clr_i -> busy_o high for exactly 256 cycles, gnt outputs held low despite requests; afterwards a read of addr 3 returns 0x0000.
- Assert rst_i at sweep cycle 100 -> busy_o=0 next cycle, pointers reset (c0 wins the first contended grant), and the remaining addresses keep their prior data.
- Both clients read continuously for 6 cycles -> rvalid pulses alternate c0,c1 with one-cycle latency and no gaps.
